// File: rtl/mem_fifo4x8_if.sv
// Producer/consumer bus for the 4x8 FIFO.
// The master side drives push/pop requests and write data; the slave side
// (the FIFO itself) returns the show-ahead read data and the status flags.
interface mem_fifo4x8_if;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       err;

    modport master (
        output wr_en,
        output wr_data,
        output rd_en,
        input  rd_data,
        input  full,
        input  empty,
        input  count,
        input  err
    );

    modport slave (
        input  wr_en,
        input  wr_data,
        input  rd_en,
        output rd_data,
        output full,
        output empty,
        output count,
        output err
    );
endinterface

// File: rtl/mem_fifo4x8.sv
// Four-entry, 8-bit show-ahead FIFO for the memory unit.
// A 2-to-4 write decoder picks the register to load, a 4:1 mux tree
// presents the oldest entry, and a 3-bit occupancy counter produces the
// full/empty flags. Requests that cannot be honoured set a sticky error.
module mem_fifo4x8 (
    input  logic         clk,
    input  logic         rst_n,
    mem_fifo4x8_if.slave bus
);

    logic [7:0] mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] cnt;
    logic       err_q;

    logic       full_int;
    logic       empty_int;
    logic       push;
    logic       pop;
    logic       overflow;
    logic       underflow;
    logic [3:0] wr_sel;
    logic [7:0] mux_lo;
    logic [7:0] mux_hi;
    logic [7:0] mux_out;

    // Flags come straight from the registered count, so they only move at an edge.
    assign full_int  = (cnt == 3'd4);
    assign empty_int = (cnt == 3'd0);

    // Acceptance uses the pre-edge flags; a full FIFO still accepts a pop
    // and an empty FIFO still accepts a push.
    assign push      = bus.wr_en & ~full_int;
    assign pop       = bus.rd_en & ~empty_int;
    assign overflow  = bus.wr_en & full_int;
    assign underflow = bus.rd_en & empty_int;

    // Write decoder: at most one register enable is raised, only on an accepted push.
    always_comb begin
        wr_sel = 4'b0000;
        if (push) begin
            wr_sel[wr_ptr] = 1'b1;
        end
    end

    // Storage registers; unselected entries hold, popped entries are not cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (wr_sel[i]) begin
                    mem[i] <= bus.wr_data;
                end
            end
        end
    end

    // Write pointer advances modulo 4 on each accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 2'd0;
        end else if (push) begin
            wr_ptr <= wr_ptr + 2'd1;
        end
    end

    // Read pointer advances modulo 4 on each accepted pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 2'd0;
        end else if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 3'd0;
        end else begin
            case ({push, pop})
                2'b10:   cnt <= cnt + 3'd1;
                2'b01:   cnt <= cnt - 3'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky error for any rejected push or pop; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (overflow | underflow) begin
            err_q <= 1'b1;
        end
    end

    // Two-level 4:1 read mux tree selected by the read pointer.
    assign mux_lo  = rd_ptr[0] ? mem[1] : mem[0];
    assign mux_hi  = rd_ptr[0] ? mem[3] : mem[2];
    assign mux_out = rd_ptr[1] ? mux_hi : mux_lo;

    assign bus.rd_data = empty_int ? 8'h00 : mux_out;
    assign bus.full    = full_int;
    assign bus.empty   = empty_int;
    assign bus.count   = cnt;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_fifo4x8.sv
// Directed self-checking bench for mem_fifo4x8.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, well away from the active edge.
module tb_mem_fifo4x8;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mem_fifo4x8_if bus ();

    mem_fifo4x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and every failure.
    task automatic check_output(input string tag, input logic [7:0] observed,
                                input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of requests and wait until just after the edge.
    task automatic apply_stimulus(input logic w, input logic [7:0] d, input logic r);
        bus.wr_en   = w;
        bus.wr_data = d;
        bus.rd_en   = r;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = 8'h00;
    endtask

    // Asynchronous reset pulse starting mid-cycle, released after an edge.
    task automatic pulse_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_count", {5'd0, bus.count}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b1;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = 8'h00;

        // Reset with no clock edge: flags must settle immediately.
        #12;
        rst_n = 1'b0;
        #1;
        check_output("reset_empty", {7'd0, bus.empty}, 8'h01);
        check_output("reset_full", {7'd0, bus.full}, 8'h00);
        check_output("reset_count", {5'd0, bus.count}, 8'h00);
        check_output("reset_err", {7'd0, bus.err}, 8'h00);
        check_output("reset_rd_data", bus.rd_data, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fill: first byte shows ahead right after its edge.
        apply_stimulus(1'b1, 8'hA1, 1'b0);
        check_output("fill1_rd_data", bus.rd_data, 8'hA1);
        check_output("fill1_count", {5'd0, bus.count}, 8'h01);
        apply_stimulus(1'b1, 8'hB2, 1'b0);
        apply_stimulus(1'b1, 8'hC3, 1'b0);
        apply_stimulus(1'b1, 8'hD4, 1'b0);
        check_output("fill_full", {7'd0, bus.full}, 8'h01);
        check_output("fill_count", {5'd0, bus.count}, 8'h04);
        check_output("fill_rd_data", bus.rd_data, 8'hA1);

        // Drain in order, ending empty with no error.
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("drain1", bus.rd_data, 8'hB2);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("drain2", bus.rd_data, 8'hC3);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("drain3", bus.rd_data, 8'hD4);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("drain4", bus.rd_data, 8'h00);
        check_output("drain_empty", {7'd0, bus.empty}, 8'h01);
        check_output("drain_err", {7'd0, bus.err}, 8'h00);

        // Overflow: refill, push while full, contents must be untouched.
        apply_stimulus(1'b1, 8'hA1, 1'b0);
        apply_stimulus(1'b1, 8'hB2, 1'b0);
        apply_stimulus(1'b1, 8'hC3, 1'b0);
        apply_stimulus(1'b1, 8'hD4, 1'b0);
        apply_stimulus(1'b1, 8'hEE, 1'b0);
        check_output("ovf_count", {5'd0, bus.count}, 8'h04);
        check_output("ovf_err", {7'd0, bus.err}, 8'h01);
        check_output("ovf_rd_data", bus.rd_data, 8'hA1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("ovf_pop1", bus.rd_data, 8'hB2);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("ovf_pop2", bus.rd_data, 8'hC3);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("ovf_pop3", bus.rd_data, 8'hD4);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("ovf_pop4", bus.rd_data, 8'h00);

        // Underflow: reset, then pop while empty.
        pulse_reset();
        check_output("udf_err_cleared", {7'd0, bus.err}, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("udf_count", {5'd0, bus.count}, 8'h00);
        check_output("udf_err", {7'd0, bus.err}, 8'h01);
        check_output("udf_empty", {7'd0, bus.empty}, 8'h01);

        // Pointer wrap: advance both pointers to 3, then push four.
        pulse_reset();
        apply_stimulus(1'b1, 8'h01, 1'b0);
        apply_stimulus(1'b1, 8'h02, 1'b0);
        apply_stimulus(1'b1, 8'h03, 1'b0);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        apply_stimulus(1'b1, 8'h11, 1'b0);
        apply_stimulus(1'b1, 8'h22, 1'b0);
        apply_stimulus(1'b1, 8'h33, 1'b0);
        check_output("wrap_not_full", {7'd0, bus.full}, 8'h00);
        apply_stimulus(1'b1, 8'h44, 1'b0);
        check_output("wrap_full", {7'd0, bus.full}, 8'h01);
        check_output("wrap_head", bus.rd_data, 8'h11);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("wrap_pop1", bus.rd_data, 8'h22);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("wrap_pop2", bus.rd_data, 8'h33);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("wrap_pop3", bus.rd_data, 8'h44);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("wrap_empty", {7'd0, bus.empty}, 8'h01);
        check_output("wrap_err", {7'd0, bus.err}, 8'h00);

        // Simultaneous push/pop at count 2: count holds, order preserved.
        apply_stimulus(1'b1, 8'h61, 1'b0);
        apply_stimulus(1'b1, 8'h62, 1'b0);
        apply_stimulus(1'b1, 8'h5A, 1'b1);
        check_output("both2_c1_count", {5'd0, bus.count}, 8'h02);
        check_output("both2_c1_rd", bus.rd_data, 8'h62);
        apply_stimulus(1'b1, 8'h5A, 1'b1);
        check_output("both2_c2_count", {5'd0, bus.count}, 8'h02);
        check_output("both2_c2_rd", bus.rd_data, 8'h5A);
        apply_stimulus(1'b1, 8'h5A, 1'b1);
        check_output("both2_c3_count", {5'd0, bus.count}, 8'h02);
        check_output("both2_err", {7'd0, bus.err}, 8'h00);
        apply_stimulus(1'b0, 8'h00, 1'b1);
        check_output("both2_tail_rd", bus.rd_data, 8'h5A);
        check_output("both2_tail_count", {5'd0, bus.count}, 8'h01);

        // Simultaneous at full: pop accepted, push rejected.
        pulse_reset();
        apply_stimulus(1'b1, 8'hF1, 1'b0);
        apply_stimulus(1'b1, 8'hF2, 1'b0);
        apply_stimulus(1'b1, 8'hF3, 1'b0);
        apply_stimulus(1'b1, 8'hF4, 1'b0);
        apply_stimulus(1'b1, 8'h99, 1'b1);
        check_output("both4_count", {5'd0, bus.count}, 8'h03);
        check_output("both4_err", {7'd0, bus.err}, 8'h01);
        check_output("both4_rd", bus.rd_data, 8'hF2);

        // Simultaneous at empty: push accepted, pop rejected.
        pulse_reset();
        apply_stimulus(1'b1, 8'h77, 1'b1);
        check_output("both0_count", {5'd0, bus.count}, 8'h01);
        check_output("both0_rd", bus.rd_data, 8'h77);
        check_output("both0_err", {7'd0, bus.err}, 8'h01);

        // Reset during traffic clears everything without waiting for an edge.
        pulse_reset();
        apply_stimulus(1'b1, 8'h81, 1'b0);
        apply_stimulus(1'b1, 8'h82, 1'b0);
        apply_stimulus(1'b1, 8'h83, 1'b0);
        check_output("traffic_pre_count", {5'd0, bus.count}, 8'h03);
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h84;
        #2;
        rst_n = 1'b0;
        #1;
        check_output("traffic_rst_count", {5'd0, bus.count}, 8'h00);
        check_output("traffic_rst_empty", {7'd0, bus.empty}, 8'h01);
        check_output("traffic_rst_rd", bus.rd_data, 8'h00);
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        rst_n       = 1'b1;
        apply_stimulus(1'b1, 8'h3C, 1'b0);
        check_output("traffic_post_rd", bus.rd_data, 8'h3C);
        check_output("traffic_post_count", {5'd0, bus.count}, 8'h01);
        check_output("traffic_post_err", {7'd0, bus.err}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
